// File: rtl/utf8_decoder_if.sv
// Byte-in / code-point-out bus of the UTF-8 decoder.
// Handshake: in_byte is valid only in a cycle where in_byte_available is high
// (1-cycle strobe, strobes at least 2 cycles apart, no backpressure);
// out_data is valid only in a cycle where out_data_available is high
// (1-cycle strobe, never stalled); decode_error is high only together with
// an out_data_available pulse that carries U+FFFD.
interface utf8_decoder_if;
  logic [7:0]  in_byte;
  logic        in_byte_available;
  logic [20:0] out_data;
  logic        out_data_available;
  logic        decode_error;

  // Byte source side (UART receiver / testbench).
  modport master (
    output in_byte,
    output in_byte_available,
    input  out_data,
    input  out_data_available,
    input  decode_error
  );

  // Decoder side.
  modport slave (
    input  in_byte,
    input  in_byte_available,
    output out_data,
    output out_data_available,
    output decode_error
  );
endinterface

// File: rtl/utf8_decoder.sv
// UTF-8 byte stream to 21-bit code point decoder.
// Malformed input becomes U+FFFD with a decode_error pulse. A stalled partial
// sequence is dropped after TIMEOUT idle cycles. Outputs are registered with
// one cycle of latency from the strobe of the final byte.
module utf8_decoder #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  utf8_decoder_if.slave        bus,
  output logic [1:0]           state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [20:0] REPL = 21'h00FFFD;
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT - 1);

  // Number of continuation bytes still expected.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NEED1 = 2'd1,
    NEED2 = 2'd2,
    NEED3 = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [14:0]   acc_q, acc_d;       // payload bits gathered so far
  logic [7:0]    lead_q, lead_d;     // lead byte of the current sequence
  logic          first_q, first_d;   // next continuation is the first one
  logic [CW-1:0] timer_q, timer_d;
  logic          pend_valid_q, pend_valid_d;
  logic [20:0]   pend_data_q, pend_data_d;
  logic          pend_err_q, pend_err_d;
  logic [20:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;

  // Lead-byte classification of the incoming byte
  logic          lead_emit;   // completes immediately (ASCII or invalid)
  logic          lead_err;
  logic [20:0]   lead_data;
  state_t        lead_state;
  logic [14:0]   lead_acc;

  // Continuation-byte check of the incoming byte
  logic [7:0]    cont_lo, cont_hi;
  logic          cont_ok;
  logic [20:0]   final_cp;

  assign state_o               = state_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_data_available = out_valid_q;
  assign bus.decode_error      = err_q;

  // Decode the incoming byte as if it were the start of a new sequence.
  always_comb begin
    lead_emit  = 1'b1;
    lead_err   = 1'b1;
    lead_data  = REPL;
    lead_state = IDLE;
    lead_acc   = '0;
    if (bus.in_byte[7] == 1'b0) begin
      lead_err  = 1'b0;
      lead_data = {13'b0, bus.in_byte};
    end else if (bus.in_byte >= 8'hC2 && bus.in_byte <= 8'hDF) begin
      lead_emit  = 1'b0;
      lead_err   = 1'b0;
      lead_state = NEED1;
      lead_acc   = {10'b0, bus.in_byte[4:0]};
    end else if (bus.in_byte >= 8'hE0 && bus.in_byte <= 8'hEF) begin
      lead_emit  = 1'b0;
      lead_err   = 1'b0;
      lead_state = NEED2;
      lead_acc   = {11'b0, bus.in_byte[3:0]};
    end else if (bus.in_byte >= 8'hF0 && bus.in_byte <= 8'hF4) begin
      lead_emit  = 1'b0;
      lead_err   = 1'b0;
      lead_state = NEED3;
      lead_acc   = {12'b0, bus.in_byte[2:0]};
    end
  end

  // Allowed continuation range; the first continuation after E0/ED/F0/F4
  // is narrowed to exclude overlongs, surrogates and values above 10FFFF.
  always_comb begin
    cont_lo = 8'h80;
    cont_hi = 8'hBF;
    if (first_q) begin
      case (lead_q)
        8'hE0:   cont_lo = 8'hA0;
        8'hED:   cont_hi = 8'h9F;
        8'hF0:   cont_lo = 8'h90;
        8'hF4:   cont_hi = 8'h8F;
        default: ;
      endcase
    end
    cont_ok  = (bus.in_byte >= cont_lo) && (bus.in_byte <= cont_hi);
    final_cp = {acc_q, bus.in_byte[5:0]};
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    lead_d       = lead_q;
    first_d      = first_q;
    timer_d      = timer_q;
    pend_valid_d = 1'b0;
    pend_data_d  = pend_data_q;
    pend_err_d   = pend_err_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    err_d        = 1'b0;

    // A result deferred by a rejected continuation goes out first; the input
    // contract keeps this cycle free of a new byte.
    if (pend_valid_q) begin
      out_data_d  = pend_data_q;
      out_valid_d = 1'b1;
      err_d       = pend_err_q;
    end

    if (bus.in_byte_available) begin
      timer_d = '0;
      if (state_q == IDLE) begin
        if (lead_emit) begin
          out_data_d  = lead_data;
          out_valid_d = 1'b1;
          err_d       = lead_err;
        end else begin
          state_d = lead_state;
          acc_d   = lead_acc;
          lead_d  = bus.in_byte;
          first_d = 1'b1;
        end
      end else if (cont_ok) begin
        first_d = 1'b0;
        acc_d   = final_cp[14:0];
        case (state_q)
          NEED1: begin
            out_data_d  = final_cp;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end
          NEED2:   state_d = NEED1;
          default: state_d = NEED2;
        endcase
      end else begin
        // Broken sequence: replace it, then treat this byte as a new lead.
        out_data_d  = REPL;
        out_valid_d = 1'b1;
        err_d       = 1'b1;
        if (lead_emit) begin
          state_d      = IDLE;
          pend_valid_d = 1'b1;
          pend_data_d  = lead_data;
          pend_err_d   = lead_err;
        end else begin
          state_d = lead_state;
          acc_d   = lead_acc;
          lead_d  = bus.in_byte;
          first_d = 1'b1;
        end
      end
    end else if (state_q != IDLE && !pend_valid_q) begin
      if (timer_q == TIMER_LAST) begin
        out_data_d  = REPL;
        out_valid_d = 1'b1;
        err_d       = 1'b1;
        state_d     = IDLE;
        timer_d     = '0;
        first_d     = 1'b0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else if (state_q == IDLE) begin
      timer_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      lead_q       <= '0;
      first_q      <= 1'b0;
      timer_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_err_q   <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      lead_q       <= lead_d;
      first_q      <= first_d;
      timer_q      <= timer_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_err_q   <= pend_err_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_utf8_decoder.sv
// Directed bench for utf8_decoder with an expected-output queue.
module tb_utf8_decoder;

  localparam int TO = 16;
  localparam logic [20:0] REPL = 21'h00FFFD;

  logic       clk;
  logic       reset;
  logic [1:0] state;
  int         cyc;
  int         n_checks;
  int         n_pass;
  logic       running;
  logic [20:0] last_data;

  logic [21:0] exp_q[$];     // {decode_error, out_data}
  int          exp_cyc_q[$]; // cycle in which the output is due

  utf8_decoder_if bus ();

  utf8_decoder #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Queue an expected output; delay counts cycles beyond the normal latency.
  task automatic expect_out(input logic [20:0] d, input logic e, input int delay);
    exp_q.push_back({e, d});
    exp_cyc_q.push_back(cyc + 1 + delay);
  endtask

  // Strobe one byte, then leave one idle cycle. Called at a negedge.
  task automatic send(input logic [7:0] b);
    bus.in_byte           = b;
    bus.in_byte_available = 1'b1;
    @(negedge clk);
    bus.in_byte_available = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: compare every output strobe against the queue head
  always @(negedge clk) begin
    if (reset || !running) begin
      last_data = '0;
    end else if (bus.out_data_available) begin
      n_checks++;
      assert (exp_q.size() != 0) n_pass++;
      else $error("FAIL unexpected_out: observed %h expected none", bus.out_data);
      if (exp_q.size() != 0) begin
        logic [21:0] e;
        int          c;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("out_data", {11'b0, bus.out_data}, {11'b0, e[20:0]});
        check("decode_error", {31'b0, bus.decode_error}, {31'b0, e[21]});
        check("out_cycle", c, cyc);
      end
      last_data = bus.out_data;
    end else begin
      check("err_without_valid", {31'b0, bus.decode_error}, 32'd0);
      check("out_data_hold", {11'b0, bus.out_data}, {11'b0, last_data});
      if (exp_cyc_q.size() != 0 && exp_cyc_q[0] < cyc) begin
        logic [21:0] e;
        int          c;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("missing_out_cycle", cyc, c);
      end
    end
  end

  initial begin
    n_checks              = 0;
    n_pass                = 0;
    running               = 1'b0;
    reset                 = 1'b1;
    bus.in_byte           = 8'h00;
    bus.in_byte_available = 1'b0;
    idle(3);
    check("rst_out_data", {11'b0, bus.out_data}, 32'd0);
    check("rst_valid", {31'b0, bus.out_data_available}, 32'd0);
    check("rst_err", {31'b0, bus.decode_error}, 32'd0);
    check("rst_state", {30'b0, state}, 32'd0);
    reset   = 1'b0;
    running = 1'b1;
    idle(2);

    // ASCII
    expect_out(21'h41, 1'b0, 0); send(8'h41);
    expect_out(21'h7F, 1'b0, 0); send(8'h7F);
    expect_out(21'h00, 1'b0, 0); send(8'h00);

    // Three-byte euro sign: output only after the last byte
    send(8'hE2);
    check("state_need2", {30'b0, state}, 32'd2);
    send(8'h82);
    check("state_need1", {30'b0, state}, 32'd1);
    expect_out(21'h020AC, 1'b0, 0); send(8'hAC);
    check("state_idle", {30'b0, state}, 32'd0);

    // Four-byte emoji
    send(8'hF0); send(8'h9F); send(8'h98);
    expect_out(21'h1F600, 1'b0, 0); send(8'h80);

    // F4 90 is above 10FFFF: FFFD, 90 as lead -> FFFD, stray 80s -> FFFD each
    send(8'hF4);
    expect_out(REPL, 1'b1, 0); expect_out(REPL, 1'b1, 1); send(8'h90);
    expect_out(REPL, 1'b1, 0); send(8'h80);
    expect_out(REPL, 1'b1, 0); send(8'h80);

    // Truncated two-byte then ASCII
    send(8'hC3);
    expect_out(REPL, 1'b1, 0); expect_out(21'h41, 1'b0, 1); send(8'h41);

    // Surrogate rejected
    send(8'hED);
    expect_out(REPL, 1'b1, 0); expect_out(REPL, 1'b1, 1); send(8'hA0);
    expect_out(REPL, 1'b1, 0); send(8'h80);

    // Overlong lead C0
    expect_out(REPL, 1'b1, 0); send(8'hC0);
    expect_out(REPL, 1'b1, 0); send(8'hAF);

    // Invalid lead F5 and E0 overlong
    expect_out(REPL, 1'b1, 0); send(8'hF5);
    send(8'hE0);
    expect_out(REPL, 1'b1, 0); expect_out(REPL, 1'b1, 1); send(8'h9F);

    // Range boundaries
    send(8'hC2); expect_out(21'h00080, 1'b0, 0); send(8'h80);
    send(8'hDF); expect_out(21'h007FF, 1'b0, 0); send(8'hBF);
    send(8'hE0); send(8'hA0); expect_out(21'h00800, 1'b0, 0); send(8'h80);
    send(8'hEF); send(8'hBF); expect_out(21'h0FFFF, 1'b0, 0); send(8'hBF);
    send(8'hED); send(8'h9F); expect_out(21'h0D7FF, 1'b0, 0); send(8'hBF);
    send(8'hF0); send(8'h90); send(8'h80); expect_out(21'h10000, 1'b0, 0); send(8'h80);
    send(8'hF4); send(8'h8F); send(8'hBF); expect_out(21'h10FFFF, 1'b0, 0); send(8'hBF);

    // Bad continuation that is itself a lead starts a new sequence
    send(8'hE2);
    expect_out(REPL, 1'b1, 0); send(8'hC3);
    check("state_restart", {30'b0, state}, 32'd1);
    expect_out(21'h000E9, 1'b0, 0); send(8'hA9);

    // Random ASCII
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 127));
      expect_out({13'b0, b}, 1'b0, 0);
      send(b);
    end

    // Timeout: E2 then silence
    expect_out(REPL, 1'b1, TO);
    send(8'hE2);
    idle(TO + 4);
    check("timeout_state", {30'b0, state}, 32'd0);

    // Reset mid-sequence discards the partial byte
    send(8'hC3);
    reset = 1'b1;
    idle(2);
    check("midrst_state", {30'b0, state}, 32'd0);
    check("midrst_out", {11'b0, bus.out_data}, 32'd0);
    check("midrst_valid", {31'b0, bus.out_data_available}, 32'd0);
    reset = 1'b0;
    idle(1);
    expect_out(21'h41, 1'b0, 0); send(8'h41);

    idle(TO + 4);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
